// File: rtl/fetch_unit.sv
// Program counter and IF/ID pipeline register for the MIPS core front end.
// Fetches from instruction memory and handles redirects, stalls, SYSCALL halt and bad-PC faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned TEXT_WORDS = 4096,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_mode,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        halted,
  output logic        fetch_fault,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  // 33-bit end bound so a text segment ending at 4 GiB does not wrap.
  localparam logic [32:0] TEXT_END = {1'b0, RESET_PC} + (33'(TEXT_WORDS) * 33'd4);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        valid_n;
  logic [31:0] instr_n;
  logic [31:0] pc4_n;
  logic        halted_n;
  logic        fault_n;
  logic [31:0] pc_plus4;
  logic        pc_bad;

  assign imem_addr = pc;
  assign state_dbg = state;
  assign pc_plus4  = pc + 32'd4;
  assign pc_bad    = (pc[1:0] != 2'b00) || (pc < RESET_PC) || ({1'b0, pc} >= TEXT_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_valid <= valid_n;
      if_id_instr <= instr_n;
      if_id_pc4   <= pc4_n;
      halted      <= halted_n;
      fetch_fault <= fault_n;
    end
  end

  // redirect_valid is a one-cycle strobe with no back-pressure: in RUN it is always
  // taken that edge and overrides stall; stall only freezes pc and IF/ID.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    valid_n  = if_id_valid;
    instr_n  = if_id_instr;
    pc4_n    = if_id_pc4;
    halted_n = halted;
    fault_n  = fetch_fault;

    if (init_mode) begin
      state_n  = S_IDLE;
      pc_n     = RESET_PC;
      valid_n  = 1'b0;
      instr_n  = 32'h0;
      pc4_n    = 32'h0;
      halted_n = 1'b0;
      fault_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: state_n = S_RUN;
        S_RUN: begin
          if (redirect_valid) begin
            pc_n    = redirect_target;
            valid_n = 1'b0;
            instr_n = 32'h0;
          end else if (pc_bad) begin
            state_n = S_FAULT;
            fault_n = 1'b1;
            valid_n = 1'b0;
            instr_n = 32'h0;
          end else if (!stall) begin
            valid_n = 1'b1;
            instr_n = imem_instr;
            pc4_n   = pc_plus4;
            pc_n    = pc_plus4;
            if (imem_instr == HALT_INSTR) begin
              state_n  = S_HALTED;
              halted_n = 1'b1;
            end
          end
        end
        S_HALTED: begin
          if (!stall) begin
            valid_n = 1'b0;
            instr_n = 32'h0;
          end
        end
        S_FAULT: begin
          valid_n = 1'b0;
          instr_n = 32'h0;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a cycle-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam int          TEXT_WORDS = 4096;
  localparam logic [31:0] HALT_INSTR = 32'h0000_000C;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n, init_mode, stall, redirect_valid;
  logic [31:0] redirect_target, imem_addr, imem_instr, if_id_instr, if_id_pc4;
  logic        if_id_valid, halted, fetch_fault;
  logic [1:0]  state_dbg;
  logic [31:0] halt_addr;

  int          total = 0;
  int          bad = 0;
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halted, m_fault;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(RESET_PC), .TEXT_WORDS(TEXT_WORDS), .HALT_INSTR(HALT_INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .init_mode(init_mode), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .halted(halted),
    .fetch_fault(fetch_fault), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return HALT_INSTR;
    if (a == RESET_PC) return 32'h2008_0005;
    if (a == RESET_PC + 32'd4) return 32'h2009_0003;
    return a ^ 32'h2008_0000;
  endfunction

  always_comb begin
    if (imem_addr == halt_addr) imem_instr = HALT_INSTR;
    else if (imem_addr == RESET_PC) imem_instr = 32'h2008_0005;
    else if (imem_addr == RESET_PC + 32'd4) imem_instr = 32'h2009_0003;
    else imem_instr = imem_addr ^ 32'h2008_0000;
  end

  // ---------------- reference model ----------------
  function automatic bit pc_is_bad(input logic [31:0] p);
    longint v;
    v = longint'(p);
    return (v % 4 != 0) || (v < longint'(RESET_PC)) ||
           (v >= longint'(RESET_PC) + 4 * longint'(TEXT_WORDS));
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = RESET_PC; m_valid = 0; m_instr = 0; m_pc4 = 0;
    m_halted = 0; m_fault = 0;
  endtask

  task automatic bubble();
    m_valid = 0; m_instr = 0;
  endtask

  task automatic model_edge();
    logic [31:0] fetched;
    fetched = mem_word(m_pc);
    if (init_mode) begin
      model_reset();
    end else if (m_mode == M_IDLE) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (redirect_valid) begin
        m_pc = redirect_target; bubble();
      end else if (pc_is_bad(m_pc)) begin
        m_mode = M_FAULT; m_fault = 1; bubble();
      end else if (!stall) begin
        m_valid = 1; m_instr = fetched; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        if (fetched == HALT_INSTR) begin m_mode = M_HALTED; m_halted = 1; end
      end
    end else if (m_mode == M_HALTED) begin
      if (!stall) bubble();
    end else begin
      bubble();
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".imem_addr"}, imem_addr, m_pc);
    check({ctx, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
    check({ctx, ".instr"}, if_id_instr, m_instr);
    check({ctx, ".pc4"}, if_id_pc4, m_pc4);
    check({ctx, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
    check({ctx, ".fault"}, {31'b0, fetch_fault}, {31'b0, m_fault});
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic set_in(input logic init, input logic stl, input logic rv, input logic [31:0] tgt);
    init_mode = init; stall = stl; redirect_valid = rv; redirect_target = tgt;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    halt_addr = 32'hFFFF_FFFF;
    set_in(1, 0, 0, 32'h0);
    model_reset();
    #12;
    check_all("reset");
    check("reset.state_dbg", {30'b0, state_dbg}, 32'd0);
    rst_n = 1'b1;

    // T1: leave init, first two fetches back to back
    cycle("t1.init");
    set_in(0, 0, 0, 32'h0);
    cycle("t1.idle");
    cycle("t1.f0");
    check("t1.pc4_0", if_id_pc4, 32'h0040_0004);
    check("t1.instr_0", if_id_instr, 32'h2008_0005);
    cycle("t1.f1");
    check("t1.pc4_1", if_id_pc4, 32'h0040_0008);
    check("t1.instr_1", if_id_instr, 32'h2009_0003);

    // T2: three-cycle stall freezes pc and IF/ID, then resumes in order
    stall = 1;
    repeat (3) begin
      cycle("t2.stall");
      check("t2.pc_frozen", imem_addr, 32'h0040_0008);
      check("t2.pc4_frozen", if_id_pc4, 32'h0040_0008);
    end
    stall = 0;
    exp_q.push_back(32'h0040_000C);
    exp_q.push_back(32'h0040_0010);
    while (exp_q.size() > 0) begin
      cycle("t2.resume");
      check("t2.order", if_id_pc4, exp_q.pop_front());
    end

    // T3: redirect wins over stall, costs one bubble
    set_in(0, 1, 1, 32'h0040_0040);
    cycle("t3.redir");
    check("t3.pc", imem_addr, 32'h0040_0040);
    check("t3.bubble", {31'b0, if_id_valid}, 32'd0);
    set_in(0, 0, 0, 32'h0);
    cycle("t3.next");
    check("t3.pc4", if_id_pc4, 32'h0040_0044);

    // Last valid word fetches, the following pc is out of range
    set_in(0, 0, 1, 32'h0040_3FFC);
    cycle("edge.redir");
    set_in(0, 0, 0, 32'h0);
    cycle("edge.last");
    check("edge.last_pc4", if_id_pc4, 32'h0040_4000);
    cycle("edge.fault");
    check("edge.fault", {31'b0, fetch_fault}, 32'd1);

    // init_mode out of FAULT, then T4 misaligned and out-of-range redirects
    init_mode = 1;
    cycle("t6.init_fault");
    check("t6.pc_reset", imem_addr, RESET_PC);
    init_mode = 0;
    cycle("t4.idle");
    set_in(0, 0, 1, 32'h0040_0042);
    cycle("t4.redir");
    set_in(0, 0, 0, 32'h0);
    cycle("t4.fault");
    check("t4.fault", {31'b0, fetch_fault}, 32'd1);
    check("t4.pc_held", imem_addr, 32'h0040_0042);
    set_in(0, 1, 1, 32'h0040_0000);
    cycle("t4.ignored");
    init_mode = 1;
    cycle("t4.init");
    set_in(0, 0, 0, 32'h0);
    cycle("t4.idle2");
    set_in(0, 0, 1, 32'h0040_4000);
    cycle("t4.redir2");
    set_in(0, 0, 0, 32'h0);
    cycle("t4.fault2");
    check("t4.fault2", {31'b0, fetch_fault}, 32'd1);

    // T5: SYSCALL at 0x0040000C halts fetch
    init_mode = 1;
    cycle("t5.init");
    init_mode = 0;
    halt_addr = 32'h0040_000C;
    cycle("t5.idle");
    repeat (4) cycle("t5.fetch");
    check("t5.instr", if_id_instr, HALT_INSTR);
    check("t5.pc4", if_id_pc4, 32'h0040_0010);
    check("t5.halted", {31'b0, halted}, 32'd1);
    set_in(0, 0, 1, 32'h0040_0040);
    cycle("t5.redir_ignored");
    check("t5.pc_hold", imem_addr, 32'h0040_0010);
    check("t5.bubble", {31'b0, if_id_valid}, 32'd0);

    // T6: init_mode out of HALTED, then asynchronous reset mid-run
    set_in(1, 0, 0, 32'h0);
    cycle("t6.init_halt");
    check("t6.halted_clr", {31'b0, halted}, 32'd0);
    init_mode = 0;
    halt_addr = 32'hFFFF_FFFF;
    repeat (4) cycle("t6.run");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    #2 rst_n = 1'b1;
    cycle("t6.idle");
    cycle("t6.refetch");
    check("t6.refetch_pc4", if_id_pc4, 32'h0040_0004);

    // Randomized traffic
    halt_addr = RESET_PC + 32'(4 * $urandom_range(8, 63));
    for (int i = 0; i < 600; i++) begin
      int kind;
      logic [31:0] tgt;
      kind = $urandom_range(0, 9);
      case (kind)
        0: tgt = RESET_PC + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
        1: tgt = 32'h0040_4000 + 32'(4 * $urandom_range(0, 3));
        2: tgt = RESET_PC - 32'(4 * $urandom_range(1, 3));
        default: tgt = RESET_PC + 32'(4 * $urandom_range(0, 63));
      endcase
      if (i % 150 == 149) halt_addr = RESET_PC + 32'(4 * $urandom_range(8, 63));
      set_in(($urandom_range(0, 99) < ((m_halted || m_fault) ? 25 : 2)),
             ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10), tgt);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
